// File: rtl/riscv_next_pkg.sv
// Shared types and helpers for the next-PC prediction strategies.
package riscv_next_pkg;

    // Decoded control-flow flags carried along the history stream.
    typedef struct packed {
        logic is_branch;
        logic is_jal;
    } next_instr_signals_t;

    // BTB controller: self-clearing sweep, then normal operation.
    typedef enum logic {
        BTB_INIT,
        BTB_RUN
    } btb_state_e;

    // Counter values a fresh entry starts at: branches weak, JALs strong.
    localparam logic [1:0] CTR_WEAK_TAKEN   = 2'b10;
    localparam logic [1:0] CTR_STRONG_TAKEN = 2'b11;

    // Tag width left over once the index and the byte-offset bits are removed.
    function automatic int btb_tag_width(input int addr_width, input int depth);
        return addr_width - $clog2(depth) - 2;
    endfunction

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

endpackage

// File: rtl/riscv_next_btb_ram.sv
// BTB entry storage: one synchronous lookup read with write-first bypass,
// one combinational read feeding the history read-modify-write, one write.
module riscv_next_btb_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata,
    input  logic [$clog2(DEPTH)-1:0] i_uaddr,
    output logic [WIDTH-1:0]         o_udata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Single write port; contents are not reset, validity lives elsewhere.
    always_ff @(posedge i_clk) begin
        if (i_we) mem[i_waddr] <= i_wdata;
    end

    // Registered lookup read; a same-cycle write to the same row wins.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                              o_rdata <= '0;
        else if (i_we && (i_waddr == i_raddr))  o_rdata <= i_wdata;
        else                                    o_rdata <= mem[i_raddr];
    end

    assign o_udata = mem[i_uaddr];

endmodule

// File: rtl/riscv_next_strategy_btb.sv
// Direct-mapped BTB jump-prediction strategy: trains from the resolved
// history stream and injects a predicted target for the PM-stage PC.
module riscv_next_strategy_btb
    import riscv_next_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic [ADDR_WIDTH-1:0] i_if_pc,
    input  logic [ADDR_WIDTH-1:0] i_pm_pc,
    input  logic                  i_pm_flush,
    output logic                  o_inject,
    output logic [ADDR_WIDTH-1:0] o_inject_addr,
    input  logic [ADDR_WIDTH-1:0] i_hist_pc,
    input  logic                  i_hist_flush,
    input  logic                  i_hist_jump_branch,
    input  logic [ADDR_WIDTH-1:0] i_hist_jump_addr,
    input  next_instr_signals_t   i_hist_signals,
    output logic                  o_busy
);

    localparam int IDXW = $clog2(DEPTH);
    localparam int TAGW = btb_tag_width(ADDR_WIDTH, DEPTH);

    // Widths depend on this instance's parameters, so the layout lives here.
    typedef struct packed {
        logic                  valid;
        logic [TAGW-1:0]       tag;
        logic [ADDR_WIDTH-1:0] target;
        logic [1:0]            ctr;
        logic                  is_jal;
    } btb_entry_t;

    localparam int EW = $bits(btb_entry_t);

    function automatic logic [IDXW-1:0] idx_of(input logic [ADDR_WIDTH-1:0] pc);
        return pc[IDXW+1:2];
    endfunction

    function automatic logic [TAGW-1:0] tag_of(input logic [ADDR_WIDTH-1:0] pc);
        return pc[ADDR_WIDTH-1:IDXW+2];
    endfunction

    btb_state_e       state;
    logic [IDXW-1:0]  cnt;
    logic [DEPTH-1:0] valid_vec;
    logic [IDXW-1:0]  idx_q;
    logic             valid_q;

    btb_entry_t       rd_entry;
    btb_entry_t       cur_entry;
    btb_entry_t       upd_entry;
    logic             upd_we;
    logic             upd_ctl;
    logic             upd_hit;
    logic [IDXW-1:0]  if_idx;
    logic [IDXW-1:0]  hist_idx;
    logic [TAGW-1:0]  hist_tag;
    logic             lookup_hit;

    assign if_idx   = idx_of(i_if_pc);
    assign hist_idx = idx_of(i_hist_pc);
    assign hist_tag = tag_of(i_hist_pc);

    riscv_next_btb_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (upd_we),
        .i_waddr (hist_idx),
        .i_wdata (upd_entry),
        .i_raddr (if_idx),
        .o_rdata (rd_entry),
        .i_uaddr (hist_idx),
        .o_udata (cur_entry)
    );

    // Sweep controller: INIT walks every row once, i_clear restarts it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= BTB_INIT;
            cnt   <= '0;
        end else begin
            case (state)
                BTB_INIT: begin
                    if (i_clear) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == IDXW'(DEPTH - 1)) state <= BTB_RUN;
                    end
                end
                default: begin
                    if (i_clear) begin
                        state <= BTB_INIT;
                        cnt   <= '0;
                    end
                end
            endcase
        end
    end

    // Valid flops: cleared one row per sweep cycle, set by any table write.
    always_ff @(posedge i_clk) begin
        if (state == BTB_INIT) valid_vec[cnt]      <= 1'b0;
        else if (upd_we)       valid_vec[hist_idx] <= 1'b1;
    end

    // History training: read-modify-write of the row the resolved PC maps to.
    assign upd_ctl = (state == BTB_RUN) && !i_clear && !i_hist_flush &&
                     (i_hist_signals.is_branch || i_hist_signals.is_jal);
    assign upd_hit = valid_vec[hist_idx] && (cur_entry.tag == hist_tag);

    // Next entry value and write enable for the training port.
    always_comb begin
        upd_we          = 1'b0;
        upd_entry       = cur_entry;
        upd_entry.valid = 1'b1;
        if (upd_ctl) begin
            if (upd_hit) begin
                upd_we           = 1'b1;
                upd_entry.is_jal = i_hist_signals.is_jal;
                if (i_hist_jump_branch) begin
                    upd_entry.ctr    = sat_inc(cur_entry.ctr);
                    upd_entry.target = i_hist_jump_addr;
                end else begin
                    upd_entry.ctr    = sat_dec(cur_entry.ctr);
                end
                // Unconditional jumps never lose confidence.
                if (upd_entry.is_jal) upd_entry.ctr = CTR_STRONG_TAKEN;
            end else if (i_hist_jump_branch) begin
                upd_we           = 1'b1;
                upd_entry.tag    = hist_tag;
                upd_entry.target = i_hist_jump_addr;
                upd_entry.is_jal = i_hist_signals.is_jal;
                upd_entry.ctr    = i_hist_signals.is_jal ? CTR_STRONG_TAKEN : CTR_WEAK_TAKEN;
            end
        end
    end

    // Lookup pipeline: index and validity travel alongside the RAM read.
    // During the sweep the row being cleared may still read as valid, so
    // validity is forced low until RUN.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            idx_q   <= if_idx;
            valid_q <= (state == BTB_RUN) &&
                       ((upd_we && (hist_idx == if_idx)) || valid_vec[if_idx]);
        end
    end

    assign lookup_hit = valid_q && (rd_entry.tag == tag_of(i_pm_pc)) &&
                        (idx_q == idx_of(i_pm_pc));

    assign o_inject      = (state == BTB_RUN) && lookup_hit && !i_pm_flush &&
                           (rd_entry.ctr[1] || rd_entry.is_jal);
    assign o_inject_addr = o_inject ? rd_entry.target : '0;
    assign o_busy        = (state == BTB_INIT);

    // Byte-offset bits and the stored valid copy are intentionally unused.
    logic unused_bits;
    assign unused_bits = ^{i_if_pc[1:0], i_pm_pc[1:0], i_hist_pc[1:0],
                           rd_entry.valid, cur_entry.valid};

endmodule

// File: tb/tb_riscv_next_strategy_btb.sv
// Directed bench for the BTB strategy with hand-computed expectations.
module tb_riscv_next_strategy_btb;
    import riscv_next_pkg::*;

    logic                i_clk = 1'b0;
    logic                i_rst;
    logic                i_clear;
    logic [15:0]         i_if_pc;
    logic [15:0]         i_pm_pc;
    logic                i_pm_flush;
    logic                o_inject;
    logic [15:0]         o_inject_addr;
    logic [15:0]         i_hist_pc;
    logic                i_hist_flush;
    logic                i_hist_jump_branch;
    logic [15:0]         i_hist_jump_addr;
    next_instr_signals_t i_hist_signals;
    logic                o_busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    riscv_next_strategy_btb #(.ADDR_WIDTH(16), .DEPTH(16)) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_clear            (i_clear),
        .i_if_pc            (i_if_pc),
        .i_pm_pc            (i_pm_pc),
        .i_pm_flush         (i_pm_flush),
        .o_inject           (o_inject),
        .o_inject_addr      (o_inject_addr),
        .i_hist_pc          (i_hist_pc),
        .i_hist_flush       (i_hist_flush),
        .i_hist_jump_branch (i_hist_jump_branch),
        .i_hist_jump_addr   (i_hist_jump_addr),
        .i_hist_signals     (i_hist_signals),
        .o_busy             (o_busy)
    );

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic hist_idle();
        i_hist_flush       = 1'b1;
        i_hist_jump_branch = 1'b0;
        i_hist_pc          = '0;
        i_hist_jump_addr   = '0;
        i_hist_signals     = '0;
    endtask

    task automatic hist_drive(input logic [15:0] pc, input logic tk, input logic [15:0] tgt,
                              input logic br, input logic jal, input logic fl);
        i_hist_pc                = pc;
        i_hist_jump_branch       = tk;
        i_hist_jump_addr         = tgt;
        i_hist_signals.is_branch = br;
        i_hist_signals.is_jal    = jal;
        i_hist_flush             = fl;
    endtask

    // One resolved instruction on the history stream for one cycle.
    task automatic hist(input logic [15:0] pc, input logic tk, input logic [15:0] tgt,
                        input logic br, input logic jal, input logic fl);
        hist_drive(pc, tk, tgt, br, jal, fl);
        step();
        hist_idle();
    endtask

    // Fetch pc, then present it in PM the next cycle and sample the result.
    task automatic lookup(input logic [15:0] pc, input logic fl,
                          output logic inj, output logic [15:0] addr);
        i_if_pc = pc;
        step();
        i_pm_pc    = pc;
        i_pm_flush = fl;
        #1;
        inj  = o_inject;
        addr = o_inject_addr;
        i_pm_flush = 1'b0;
    endtask

    // Count consecutive busy cycles (bounded).
    task automatic count_busy(output int n, output logic inj_seen);
        n = 0;
        inj_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (o_inject) inj_seen = 1'b1;
            if (!o_busy) break;
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        int   n;
        logic inj;
        logic [15:0] addr;
        i_rst = 1'b1;
        i_clear = 1'b0; i_pm_flush = 1'b0; i_if_pc = '0; i_pm_pc = '0;
        hist_idle();
        step(); step();
        n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b want 1", o_busy); end
        n_cmp++; if (o_inject !== 1'b0) begin n_err++; $display("FAIL reset_inject: got %b want 0", o_inject); end
        n_cmp++; if (o_inject_addr !== 16'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0000", o_inject_addr); end
        i_rst = 1'b0;
        n = 0; inj = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (i == 5) hist_drive(16'h0040, 1'b1, 16'h0100, 1'b1, 1'b0, 1'b0);
            if (i == 6) hist_idle();
            if (o_inject) inj = 1'b1;
            if (!o_busy) break;
            n++;
            step();
        end
        hist_idle();
        n_cmp++; if (n != 16) begin n_err++; $display("FAIL sweep_len: got %0d want 16", n); end
        n_cmp++; if (inj !== 1'b0) begin n_err++; $display("FAIL sweep_inject: got %b want 0", inj); end
        lookup(16'h0040, 1'b0, inj, addr);
        n_cmp++; if (inj !== 1'b0) begin n_err++; $display("FAIL sweep_drop_update: got inj=%b want 0", inj); end
    endtask

    task automatic test_alloc();
        logic inj;
        logic [15:0] addr;
        hist(16'h0040, 1'b1, 16'h0100, 1'b1, 1'b0, 1'b0);
        lookup(16'h0040, 1'b0, inj, addr);
        n_cmp++; if (inj !== 1'b1 || addr !== 16'h0100) begin n_err++; $display("FAIL alloc_hit: got %b/%h want 1/0100", inj, addr); end
        // Fetch 0x40 but PM holds 0x44: index mismatch must not inject.
        i_if_pc = 16'h0040; step(); i_pm_pc = 16'h0044; #1;
        n_cmp++; if (o_inject !== 1'b0 || o_inject_addr !== 16'h0) begin n_err++; $display("FAIL alloc_pm_mismatch: got %b/%h want 0/0000", o_inject, o_inject_addr); end
    endtask

    task automatic test_hysteresis();
        logic inj;
        logic [15:0] addr;
        hist(16'h0040, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);                     // 2 -> 1
        lookup(16'h0040, 1'b0, inj, addr);
        n_cmp++; if (inj !== 1'b0) begin n_err++; $display("FAIL hyst_ctr1: got %b want 0", inj); end
        hist(16'h0040, 1'b1, 16'h0100, 1'b1, 1'b0, 1'b0);                     // 1 -> 2
        lookup(16'h0040, 1'b0, inj, addr);
        n_cmp++; if (inj !== 1'b1 || addr !== 16'h0100) begin n_err++; $display("FAIL hyst_ctr2: got %b/%h want 1/0100", inj, addr); end
        hist(16'h0040, 1'b1, 16'h0104, 1'b1, 1'b0, 1'b0);                     // 2 -> 3
        hist(16'h0040, 1'b1, 16'h0104, 1'b1, 1'b0, 1'b0);                     // 3 stays 3
        hist(16'h0040, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);                     // 3 -> 2
        lookup(16'h0040, 1'b0, inj, addr);
        n_cmp++; if (inj !== 1'b1 || addr !== 16'h0104) begin n_err++; $display("FAIL hyst_sat_hi: got %b/%h want 1/0104", inj, addr); end
        hist(16'h0040, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);                     // 2 -> 1
        hist(16'h0040, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);                     // 1 -> 0
        hist(16'h0040, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);                     // 0 stays 0
        lookup(16'h0040, 1'b0, inj, addr);
        n_cmp++; if (inj !== 1'b0) begin n_err++; $display("FAIL hyst_ctr0: got %b want 0", inj); end
        hist(16'h0040, 1'b1, 16'h0100, 1'b1, 1'b0, 1'b0);                     // 0 -> 1
        lookup(16'h0040, 1'b0, inj, addr);
        n_cmp++; if (inj !== 1'b0) begin n_err++; $display("FAIL hyst_sat_lo: got %b want 0", inj); end
        hist(16'h0040, 1'b1, 16'h0100, 1'b1, 1'b0, 1'b0);                     // 1 -> 2
        lookup(16'h0040, 1'b0, inj, addr);
        n_cmp++; if (inj !== 1'b1 || addr !== 16'h0100) begin n_err++; $display("FAIL hyst_recover: got %b/%h want 1/0100", inj, addr); end
    endtask

    task automatic test_alias();
        logic inj;
        logic [15:0] addr;
        lookup(16'h0440, 1'b0, inj, addr);
        n_cmp++; if (inj !== 1'b0) begin n_err++; $display("FAIL alias_miss: got %b want 0", inj); end
        hist(16'h0840, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);                     // miss, not taken
        hist(16'h0050, 1'b1, 16'h0250, 1'b0, 1'b0, 1'b0);                     // not control-flow
        hist(16'h0060, 1'b1, 16'h0260, 1'b1, 1'b0, 1'b1);                     // flushed slot
        lookup(16'h0040, 1'b0, inj, addr);
        n_cmp++; if (inj !== 1'b1 || addr !== 16'h0100) begin n_err++; $display("FAIL alias_nt_nowrite: got %b/%h want 1/0100", inj, addr); end
        lookup(16'h0050, 1'b0, inj, addr);
        n_cmp++; if (inj !== 1'b0) begin n_err++; $display("FAIL ignore_noncontrol: got %b want 0", inj); end
        lookup(16'h0060, 1'b0, inj, addr);
        n_cmp++; if (inj !== 1'b0) begin n_err++; $display("FAIL ignore_hist_flush: got %b want 0", inj); end
        hist(16'h0440, 1'b1, 16'h0200, 1'b1, 1'b0, 1'b0);
        lookup(16'h0440, 1'b0, inj, addr);
        n_cmp++; if (inj !== 1'b1 || addr !== 16'h0200) begin n_err++; $display("FAIL alias_replace: got %b/%h want 1/0200", inj, addr); end
        lookup(16'h0040, 1'b0, inj, addr);
        n_cmp++; if (inj !== 1'b0) begin n_err++; $display("FAIL alias_evicted: got %b want 0", inj); end
    endtask

    task automatic test_collision();
        logic inj;
        logic [15:0] addr;
        hist(16'h0080, 1'b1, 16'h0180, 1'b1, 1'b0, 1'b0);
        // Update and fetch of the same row in one cycle.
        i_if_pc = 16'h0080;
        hist_drive(16'h0080, 1'b1, 16'h0190, 1'b1, 1'b0, 1'b0);
        step();
        hist_idle();
        i_pm_pc = 16'h0080; #1;
        n_cmp++; if (o_inject !== 1'b1 || o_inject_addr !== 16'h0190) begin n_err++; $display("FAIL collide_fwd: got %b/%h want 1/0190", o_inject, o_inject_addr); end
        lookup(16'h0080, 1'b1, inj, addr);
        n_cmp++; if (inj !== 1'b0 || addr !== 16'h0) begin n_err++; $display("FAIL pm_flush: got %b/%h want 0/0000", inj, addr); end
        // Allocation into an empty row while it is being fetched.
        i_if_pc = 16'h0094;
        hist_drive(16'h0094, 1'b1, 16'h02a0, 1'b1, 1'b0, 1'b0);
        step();
        hist_idle();
        i_pm_pc = 16'h0094; #1;
        n_cmp++; if (o_inject !== 1'b1 || o_inject_addr !== 16'h02a0) begin n_err++; $display("FAIL collide_alloc: got %b/%h want 1/02a0", o_inject, o_inject_addr); end
    endtask

    task automatic test_clear();
        int   n;
        logic inj;
        logic [15:0] addr;
        i_clear = 1'b1;
        hist_drive(16'h00c0, 1'b1, 16'h03c0, 1'b1, 1'b0, 1'b0);               // dropped with clear
        step();
        i_clear = 1'b0;
        hist_idle();
        n = 0;
        for (int i = 0; i < 60; i++) begin
            if (i == 3) i_clear = 1'b1;                                       // restart mid-sweep
            if (i == 4) i_clear = 1'b0;
            if (!o_busy) break;
            n++;
            step();
        end
        i_clear = 1'b0;
        n_cmp++; if (n != 20) begin n_err++; $display("FAIL clear_sweep_len: got %0d want 20", n); end
        lookup(16'h0080, 1'b0, inj, addr);
        n_cmp++; if (inj !== 1'b0) begin n_err++; $display("FAIL clear_0080: got %b want 0", inj); end
        lookup(16'h0094, 1'b0, inj, addr);
        n_cmp++; if (inj !== 1'b0) begin n_err++; $display("FAIL clear_0094: got %b want 0", inj); end
        lookup(16'h00c0, 1'b0, inj, addr);
        n_cmp++; if (inj !== 1'b0) begin n_err++; $display("FAIL clear_drop_update: got %b want 0", inj); end
        hist(16'h0010, 1'b1, 16'h0300, 1'b0, 1'b1, 1'b0);
        lookup(16'h0010, 1'b0, inj, addr);
        n_cmp++; if (inj !== 1'b1 || addr !== 16'h0300) begin n_err++; $display("FAIL jal_alloc: got %b/%h want 1/0300", inj, addr); end
    endtask

    task automatic test_back_to_back();
        // Held fetch PC: the same row is re-read every cycle.
        i_if_pc = 16'h0010;
        i_pm_pc = 16'h0010;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (o_inject !== 1'b1 || o_inject_addr !== 16'h0300) begin n_err++; $display("FAIL stall_%0d: got %b/%h want 1/0300", i, o_inject, o_inject_addr); end
        end
        // JAL not taken still keeps the strong counter.
        hist(16'h0010, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        step();
        n_cmp++; if (o_inject !== 1'b1 || o_inject_addr !== 16'h0300) begin n_err++; $display("FAIL jal_forced: got %b/%h want 1/0300", o_inject, o_inject_addr); end
    endtask

    task automatic test_async_reset();
        int   n;
        logic inj;
        logic [15:0] addr;
        i_if_pc = 16'h0010;
        i_pm_pc = 16'h0010;
        step();
        #1;
        i_rst = 1'b1;
        #1;
        n_cmp++; if (o_busy !== 1'b1 || o_inject !== 1'b0 || o_inject_addr !== 16'h0) begin n_err++; $display("FAIL async_reset: got busy=%b inj=%b addr=%h want 1/0/0000", o_busy, o_inject, o_inject_addr); end
        step();
        i_rst = 1'b0;
        count_busy(n, inj);
        n_cmp++; if (n != 16 || inj !== 1'b0) begin n_err++; $display("FAIL async_sweep: got len=%0d inj=%b want 16/0", n, inj); end
        lookup(16'h0010, 1'b0, inj, addr);
        n_cmp++; if (inj !== 1'b0) begin n_err++; $display("FAIL async_cleared: got %b want 0", inj); end
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_hysteresis();
        test_alias();
        test_collision();
        test_clear();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
